// File: rtl/alu_driver.sv
`default_nettype none
// alu_driver: accepts one command, drives a registered ALU, waits SETTLE_CYC cycles, returns the result.
// Optional reference check enabled by macro ALU_DRIVER_CHECK_EN.  Rev 1.0
module alu_driver #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_enable,
  input  logic [31:0] alu_salida,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_inv,
  output logic        rsp_mismatch,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  settle_cnt;
  logic        accept;
  logic        capture;
  logic        done;
  logic        inv_sel;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign inv_sel   = (alu_sel == 3'b101) || (alu_sel == 3'b110);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_enable <= 1'b0;
      settle_cnt <= '0;
      rsp_data   <= '0;
      rsp_inv    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_sel    <= cmd_sel;
        alu_enable <= 1'b1;
        settle_cnt <= 4'(SETTLE_CYC - 1);
      end else if (capture) begin
        rsp_data   <= alu_salida;
        rsp_inv    <= inv_sel;
        alu_enable <= 1'b0;
      end else if (state == WAIT) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (done) op_count <= op_count + 16'd1;
    end
  end

`ifdef ALU_DRIVER_CHECK_EN
  // Reference result from the registered operands; invalid selects expect 0.
  logic [31:0] expected;

  always_comb begin
    expected = '0;
    case (alu_sel)
      3'b000:  expected = alu_a & alu_b;
      3'b001:  expected = alu_a | alu_b;
      3'b010:  expected = alu_a + alu_b;
      3'b011:  expected = alu_a - alu_b;
      3'b100:  expected = ~(alu_a & alu_b);
      3'b111:  expected = alu_a * alu_b;
      default: expected = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          rsp_mismatch <= 1'b0;
    else if (capture) rsp_mismatch <= (alu_salida != expected);
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// tb_alu_driver: directed self-checking bench for alu_driver (SETTLE_CYC = 2).
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic        alu_enable;
  logic [31:0] alu_salida;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_inv;
  logic        rsp_mismatch;
  logic [15:0] op_count;

  logic        alu_bug;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  alu_driver #(.SETTLE_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_sel      (cmd_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_enable   (alu_enable),
    .alu_salida   (alu_salida),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_inv      (rsp_inv),
    .rsp_mismatch (rsp_mismatch),
    .op_count     (op_count)
  );

  // Behavioural ALU; alu_bug corrupts add by +1.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_salida = alu_a & alu_b;
      3'b001:  alu_salida = alu_a | alu_b;
      3'b010:  alu_salida = alu_bug ? (alu_a + alu_b + 32'd1) : (alu_a + alu_b);
      3'b011:  alu_salida = alu_a - alu_b;
      3'b100:  alu_salida = ~(alu_a & alu_b);
      3'b111:  alu_salida = alu_a * alu_b;
      default: alu_salida = 32'd0;
    endcase
  end

  // Presents a command at a negedge and returns 1 ns after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, counting edges after the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; alu_bug = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, alu_enable, rsp_valid, rsp_inv, rsp_mismatch} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 10000",
               {cmd_ready, alu_enable, rsp_valid, rsp_inv, rsp_mismatch});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, rsp_data, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: alu_a=%h alu_b=%h sel=%b data=%h cnt=%h expected all 0",
               alu_a, alu_b, alu_sel, rsp_data, op_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_ops();
    logic [31:0] va [7] = '{32'd4201, 32'd4201, 32'd4201, 32'd8, 32'd6, 32'd10, 32'd4};
    logic [31:0] vb [7] = '{32'd6669, 32'd6669, 32'd6669, 32'd16, 32'd12, 32'd24, 32'd100};
    logic [2:0]  vs [7] = '{3'b000, 3'b001, 3'b100, 3'b010, 3'b011, 3'b111, 3'b111};
    logic [31:0] vr [7] = '{32'd4105, 32'd6765, 32'hFFFFEFF6, 32'd24, 32'hFFFFFFFA, 32'd240, 32'd400};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vs[i]);
      checks++;
      if (alu_enable !== 1'b1 || alu_a !== va[i] || alu_b !== vb[i] || alu_sel !== vs[i]) begin
        errors++;
        $display("FAIL op%0d_drive: en=%b a=%h b=%h sel=%b expected en=1 a=%h b=%h sel=%b",
                 i, alu_enable, alu_a, alu_b, alu_sel, va[i], vb[i], vs[i]);
      end
      wait_rsp(lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d expected 2", i, lat);
      end
      checks++;
      if (rsp_data !== vr[i] || rsp_inv !== 1'b0 || rsp_mismatch !== 1'b0 || alu_enable !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_result: data=%h inv=%b mism=%b en=%b expected data=%h inv=0 mism=0 en=0",
                 i, rsp_data, rsp_inv, rsp_mismatch, alu_enable, vr[i]);
      end
      handshake();
      exp_count++;
      checks++;
      if (op_count !== exp_count || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL op%0d_count: cnt=%h ready=%b expected cnt=%h ready=1",
                 i, op_count, cmd_ready, exp_count);
      end
    end
  endtask

  task automatic test_invalid();
    logic [2:0] sels [2] = '{3'b110, 3'b101};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue(32'd8, 32'd16, sels[i]);
      wait_rsp(lat);
      checks++;
      if (lat !== 2 || rsp_data !== 32'd0 || rsp_inv !== 1'b1 || rsp_mismatch !== 1'b0) begin
        errors++;
        $display("FAIL invalid_sel%b: lat=%0d data=%h inv=%b mism=%b expected lat=2 data=0 inv=1 mism=0",
                 sels[i], lat, rsp_data, rsp_inv, rsp_mismatch);
      end
      handshake();
      exp_count++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] held;
    issue(32'd8, 32'd16, 3'b010);
    wait_rsp(lat);
    held = rsp_data;
    @(negedge clk);
    cmd_a = 32'h1234_5678; cmd_b = 32'd3; cmd_sel = 3'b001; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== held || rsp_data !== 32'd24 ||
          rsp_inv !== 1'b0 || alu_a !== 32'd8 || alu_enable !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d: ready=%b valid=%b data=%h inv=%b alu_a=%h en=%b expected 0/1/00000018/0/00000008/0",
                 i, cmd_ready, rsp_valid, rsp_data, rsp_inv, alu_a, alu_enable);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count++;
    checks++;
    if (op_count !== exp_count || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: cnt=%h ready=%b valid=%b expected cnt=%h ready=1 valid=0",
               op_count, cmd_ready, rsp_valid, exp_count);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    issue(32'd5, 32'd7, 3'b010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, alu_enable, rsp_valid, rsp_inv, rsp_mismatch} !== 5'b10000 ||
        {alu_a, alu_b, alu_sel, rsp_data, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_wait: ready=%b en=%b valid=%b a=%h b=%h sel=%b data=%h cnt=%h expected reset values",
               cmd_ready, alu_enable, rsp_valid, alu_a, alu_b, alu_sel, rsp_data, op_count);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    exp_count = 16'd0;
    checks++;
    if (seen !== 1'b0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_wait_after: rsp_seen=%b cnt=%h expected 0 0", seen, op_count);
    end
  endtask

  task automatic test_reset_in_resp();
    int lat;
    issue(32'd1, 32'd2, 3'b010);
    wait_rsp(lat);
    handshake();
    exp_count++;
    issue(32'd3, 32'd4, 3'b010);
    wait_rsp(lat);
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    exp_count = 16'd0;
    checks++;
    if (op_count !== 16'd0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_resp: cnt=%h valid=%b data=%h ready=%b expected 0 0 0 1",
               op_count, rsp_valid, rsp_data, cmd_ready);
    end
  endtask

  task automatic test_wrap();
    int lat;
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", op_count);
    end
    issue(32'd2, 32'd3, 3'b111);
    wait_rsp(lat);
    handshake();
    checks++;
    if (op_count !== 16'h0000 || rsp_data !== 32'd6) begin
      errors++;
      $display("FAIL wrap: cnt=%h data=%h expected 0000 00000006", op_count, rsp_data);
    end
    exp_count = 16'd0;
  endtask

  task automatic test_mismatch();
    int lat;
    logic exp_mism;
`ifdef ALU_DRIVER_CHECK_EN
    exp_mism = 1'b1;
`else
    exp_mism = 1'b0;
`endif
    alu_bug = 1'b1;
    issue(32'd2524, 32'd1, 3'b010);
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 32'd2526 || rsp_mismatch !== exp_mism || rsp_inv !== 1'b0) begin
      errors++;
      $display("FAIL mismatch: data=%0d mism=%b inv=%b expected data=2526 mism=%b inv=0",
               rsp_data, rsp_mismatch, rsp_inv, exp_mism);
    end
    handshake();
    alu_bug = 1'b0;
    issue(32'd2524, 32'd1, 3'b010);
    wait_rsp(lat);
    checks++;
    if (rsp_data !== 32'd2525 || rsp_mismatch !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_clear: data=%0d mism=%b expected data=2525 mism=0", rsp_data, rsp_mismatch);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_ops();
    test_invalid();
    test_back_to_back();
    test_reset_in_wait();
    test_reset_in_resp();
    test_wrap();
    test_mismatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
